pool3_layer: RTL

- 2x2 stride-2 signed max-pool stage directly downstream of the conv3 layer.
- Consumes the conv3 output blob stream: 64-bit words, 4 channels × 16-bit signed, ReLU already applied upstream. Produces the pooled blob in the same word format for the next layer.
- Uses a single partial-max line buffer of (W_IN/2)·GROUPS words, updated read-modify-write on every input beat.
- Frame-level rdy plus beat-level en/eop handshake, identical to the conv layers.

---
 rtl/pool3_layer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pool3_layer.sv
// 2x2 stride-2 signed max-pool over a 4-lane x 16-bit blob stream.
// A single partial-max line buffer holds one pooled row, updated on every input beat.
module pool3_layer #(
  parameter int unsigned W_IN = 8,
  parameter int unsigned H_IN = 8,
  parameter int unsigned C    = 64,
  parameter int unsigned KPF  = 4,
  parameter int unsigned DW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              blob_din_rdy,
  input  logic              blob_din_en,
  input  logic              blob_din_eop,
  input  logic [KPF*DW-1:0] blob_din,
  input  logic              blob_dout_rdy,
  output logic              blob_dout_en,
  output logic              blob_dout_eop,
  output logic [KPF*DW-1:0] blob_dout,
  output logic              frame_err
);

  localparam int unsigned GROUPS   = C / KPF;
  localparam int unsigned LB_DEPTH = (W_IN / 2) * GROUPS;
  localparam int unsigned BW       = KPF * DW;
  localparam int unsigned GW       = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned WW       = $clog2(W_IN);
  localparam int unsigned HW       = $clog2(H_IN);
  localparam int unsigned AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [WW-1:0]   w_q, w_d;
  logic [HW-1:0]   h_q, h_d;
  logic [BW-1:0]   lb [LB_DEPTH];

  logic            last_g_c, last_w_c, last_h_c, final_c;
  logic            beat_ok_c, beat_bad_c, frame_end_c, pool_c;
  logic [AW-1:0]   addr_c;
  logic [BW-1:0]   lb_rd_c, max_c, wr_data_c;

  logic            din_rdy_d, dout_en_d, dout_eop_d, err_d;
  logic [BW-1:0]   dout_d;

  // Beat classification and line-buffer addressing
  always_comb begin
    last_g_c    = (g_q == GW'(GROUPS - 1));
    last_w_c    = (w_q == WW'(W_IN - 1));
    last_h_c    = (h_q == HW'(H_IN - 1));
    final_c     = last_g_c && last_w_c && last_h_c;
    beat_ok_c   = blob_din_en && ((state_q == RUN) || ((state_q == IDLE) && blob_din_rdy));
    beat_bad_c  = blob_din_en && !beat_ok_c;
    frame_end_c = beat_ok_c && (final_c || blob_din_eop);
    pool_c      = h_q[0] && w_q[0];
    addr_c      = AW'(32'(w_q >> 1) * GROUPS + 32'(g_q));
    lb_rd_c     = lb[addr_c];
  end

  // Lanewise signed max of the stored partial and the incoming word
  always_comb begin
    max_c = '0;
    for (int unsigned k = 0; k < KPF; k++) begin
      if ($signed(lb_rd_c[k*DW +: DW]) > $signed(blob_din[k*DW +: DW]))
        max_c[k*DW +: DW] = lb_rd_c[k*DW +: DW];
      else
        max_c[k*DW +: DW] = blob_din[k*DW +: DW];
    end
    wr_data_c = (!h_q[0] && !w_q[0]) ? blob_din : max_c;
  end

  // Raster counters g -> w -> h; an early eop also restarts the frame
  always_comb begin
    g_d = g_q;
    w_d = w_q;
    h_d = h_q;
    if (beat_ok_c) begin
      if (frame_end_c) begin
        g_d = '0;
        w_d = '0;
        h_d = '0;
      end else if (!last_g_c) begin
        g_d = g_q + GW'(1);
      end else begin
        g_d = '0;
        if (!last_w_c) begin
          w_d = w_q + WW'(1);
        end else begin
          w_d = '0;
          h_d = h_q + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: begin
        if (beat_ok_c) begin
          if (final_c)           state_d = DRAIN;
          else if (blob_din_eop) state_d = IDLE;
          else                   state_d = RUN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    din_rdy_d  = (state_d == IDLE) && blob_dout_rdy;
    dout_en_d  = beat_ok_c && pool_c;
    dout_eop_d = beat_ok_c && pool_c && (final_c || blob_din_eop);
    dout_d     = (beat_ok_c && pool_c) ? max_c : blob_dout;
    err_d      = frame_err || beat_bad_c || (beat_ok_c && (blob_din_eop != final_c));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q           <= '0;
      w_q           <= '0;
      h_q           <= '0;
      blob_din_rdy  <= 1'b0;
      blob_dout_en  <= 1'b0;
      blob_dout_eop <= 1'b0;
      blob_dout     <= '0;
      frame_err     <= 1'b0;
    end else begin
      g_q           <= g_d;
      w_q           <= w_d;
      h_q           <= h_d;
      blob_din_rdy  <= din_rdy_d;
      blob_dout_en  <= dout_en_d;
      blob_dout_eop <= dout_eop_d;
      blob_dout     <= dout_d;
      frame_err     <= err_d;
    end
  end

  // Line buffer carries no reset: even-row/even-col beats always overwrite first
  always_ff @(posedge clk) begin
    if (beat_ok_c) lb[addr_c] <= wr_data_c;
  end

endmodule
